fifo_nibble_packer: RTL and testbench

//   Read-side consumer of the CDC FIFO: pops 4-bit entries from the FIFO read port and packs PACK

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_nibble_packer_if.sv | 38 +++
 rtl/nibble_gather_reg.sv | 74 +++++++
 rtl/fifo_nibble_packer.sv | 86 ++++++++
 tb/tb_fifo_nibble_packer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FIFO consumer.
// Holds the FIFO geometry constants, which the FIFO instance also uses, the
// packer state encoding, and a helper that sizes nibble counters.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH    = 4;
  localparam int FIFO_ADDRESS_WIDTH = 5;

  typedef enum logic {
    GATHER = 1'b0,
    HOLD   = 1'b1
  } pack_state_t;

  // Width of a counter that must hold every value 0..pack inclusive.
  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_nibble_packer_if.sv
// Bundle of FIFO read-port and packed-word output signals for fifo_nibble_packer.
//   fifo_empty, fifo_read_data   : FIFO head (read domain)
//   fifo_read_increment          : pop strobe back to the FIFO
//   flush                        : force out a partial word
//   out_data/out_count/out_valid : packed word, valid/ready handshake with out_ready
// Modports:
//   master : the packer (drives the pop strobe and the word port)
//   slave  : the surroundings (FIFO plus word consumer)
interface fifo_nibble_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PACK       = 2
) ();

  localparam int OUT_WIDTH = DATA_WIDTH * PACK;
  localparam int CNT_WIDTH = cnt_width(PACK);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_read_increment;
  logic                  flush;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  out_count;

  modport master (
    input  fifo_empty, fifo_read_data, flush, out_ready,
    output fifo_read_increment, out_data, out_valid, out_count
  );

  modport slave (
    output fifo_empty, fifo_read_data, flush, out_ready,
    input  fifo_read_increment, out_data, out_valid, out_count
  );

endinterface

// File: rtl/nibble_gather_reg.sv
// PACK-slot gather register with fill counter.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : clear all slots and the fill counter
//   wr_i         : write wr_data_i into slot [fill] (slot 0 when clr_i is also set)
//   wr_data_i    : entry to capture
//   data_o       : all slots concatenated, slot 0 in the least significant bits
//   fill_o       : number of slots written since the last clear
// Cleared slots read zero, so a partially filled word has zeros in its
// unused upper slots without any extra masking downstream.
module nibble_gather_reg #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK       = 2,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       wr_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  output logic [DATA_WIDTH*PACK-1:0] data_o,
  output logic [CNT_WIDTH-1:0]       fill_o
);

  logic [CNT_WIDTH-1:0] fill_q;
  logic [CNT_WIDTH-1:0] fill_d;

  always_comb begin
    fill_d = fill_q;
    if (clr_i) begin
      fill_d = wr_i ? CNT_WIDTH'(1) : '0;
    end else if (wr_i) begin
      fill_d = fill_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill_o = fill_q;

  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_q;
      logic [DATA_WIDTH-1:0] slot_d;

      always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
          // Clear-and-write lands the new entry in slot 0 only.
          slot_d = (wr_i && (gi == 0)) ? wr_data_i : '0;
        end else if (wr_i && (fill_q == CNT_WIDTH'(gi))) begin
          slot_d = wr_data_i;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_q <= '0;
        end else begin
          slot_q <= slot_d;
        end
      end

      assign data_o[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q;
    end
  endgenerate

endmodule

// File: rtl/fifo_nibble_packer.sv
// Read-side consumer of the CDC FIFO: pops DATA_WIDTH-bit entries and packs
// PACK of them into one word presented on a valid/ready port. A level flush
// pushes out a partially filled word. Runs in the FIFO read-clock domain.
// Ports:
//   clk   : FIFO read clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_nibble_packer_if.master (FIFO read port, flush, word port)
// The gather register doubles as the output register: while holding, no
// pops occur except on the accept edge, so its contents stay stable.
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int PACK       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_nibble_packer_if.master bus
);

  localparam int OUT_WIDTH = DATA_WIDTH * PACK;
  localparam int CNT_WIDTH = cnt_width(PACK);

  pack_state_t          state_q;
  pack_state_t          state_d;
  logic                 accept;
  logic                 pop;
  logic                 word_done;
  logic                 flush_now;
  logic [CNT_WIDTH-1:0] fill;
  logic [OUT_WIDTH-1:0] word;

  assign accept = (state_q == HOLD) && bus.out_ready;
  // fifo_empty is a FIFO register output, so this path has no loop.
  // Gating with rst_n keeps the strobe low for the whole reset interval.
  assign pop    = rst_n && !bus.fifo_empty && ((state_q == GATHER) || accept);

  // A coincident pop counts toward completion in the same edge.
  assign word_done = (fill + CNT_WIDTH'(pop)) == CNT_WIDTH'(PACK);
  assign flush_now = bus.flush && ((fill != '0) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GATHER;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GATHER: begin
        if (word_done || flush_now) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = GATHER;
        end
      end
      default: state_d = GATHER;
    endcase
  end

  nibble_gather_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK       (PACK),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_gather (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept),
    .wr_i      (pop),
    .wr_data_i (bus.fifo_read_data),
    .data_o    (word),
    .fill_o    (fill)
  );

  assign bus.fifo_read_increment = pop;
  assign bus.out_valid           = (state_q == HOLD);
  assign bus.out_data            = word;
  assign bus.out_count           = fill;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
module tb_fifo_nibble_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2_n = 1'b0;
  logic rst4_n = 1'b0;

  fifo_nibble_packer_if #(.DATA_WIDTH(4), .PACK(2)) b2 ();
  fifo_nibble_packer_if #(.DATA_WIDTH(4), .PACK(4)) b4 ();

  fifo_nibble_packer #(.DATA_WIDTH(4), .PACK(2)) u2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (b2.master)
  );

  fifo_nibble_packer #(.DATA_WIDTH(4), .PACK(4)) u4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (b4.master)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- FIFO model for the PACK=2 instance ----------------
  logic [3:0] q2[$];
  logic [3:0] pushed2[$];
  logic       push2 = 1'b0;
  logic [3:0] push2_data = 4'h0;
  int         pops2 = 0;

  always @(posedge clk) begin
    if (b2.fifo_read_increment === 1'b1) begin
      chk("pop_while_empty", b2.fifo_empty, 1'b0);
      if (q2.size() != 0) void'(q2.pop_front());
      pops2++;
    end
    if (push2) begin
      q2.push_back(push2_data);
      pushed2.push_back(push2_data);
    end
    b2.fifo_empty     <= (q2.size() == 0);
    b2.fifo_read_data <= (q2.size() != 0) ? q2[0] : 4'h0;
  end

  // ---------------- FIFO model for the PACK=4 instance ----------------
  logic [3:0] q4[$];
  logic       push4 = 1'b0;
  logic [3:0] push4_data = 4'h0;
  int         pops4 = 0;

  always @(posedge clk) begin
    if (b4.fifo_read_increment === 1'b1) begin
      chk("pop_while_empty4", b4.fifo_empty, 1'b0);
      if (q4.size() != 0) void'(q4.pop_front());
      pops4++;
    end
    if (push4) q4.push_back(push4_data);
    b4.fifo_empty     <= (q4.size() == 0);
    b4.fifo_read_data <= (q4.size() != 0) ? q4[0] : 4'h0;
  end

  // ---------------- Reference model (PACK=2) ----------------
  // Nibbles gathered so far, and the word currently offered (if any).
  logic [3:0] m_pend[$];
  logic [3:0] m_held[$];
  bit         m_hold = 1'b0;

  always @(posedge clk) begin
    if (!rst2_n) begin
      m_pend.delete();
      m_held.delete();
      m_hold = 1'b0;
    end else begin
      bit gath, acc, pop;
      gath = !m_hold;
      acc  = m_hold && b2.out_ready;
      pop  = !b2.fifo_empty && (gath || acc);
      chk("pop_rule", b2.fifo_read_increment, pop);
      if (acc) begin
        m_held.delete();
        m_hold = 1'b0;
      end
      if (pop) m_pend.push_back(b2.fifo_read_data);
      if (m_pend.size() == 2 || (gath && b2.flush && m_pend.size() > 0)) begin
        m_held = m_pend;
        m_pend.delete();
        m_hold = 1'b1;
      end
    end
  end

  // Per-cycle output compare, away from the active edge.
  int vcnt2 = 0;
  always @(negedge clk) begin
    if (rst2_n) begin
      logic [7:0] w;
      w = 8'h00;
      for (int i = 0; i < m_held.size(); i++) w[i*4 +: 4] = m_held[i];
      chk("out_valid", b2.out_valid, m_hold);
      if (m_hold) begin
        chk("out_data", b2.out_data, w);
        chk("out_count", b2.out_count, m_held.size());
      end
      if (b2.out_valid) vcnt2++;
    end
  end

  // Log of accepted words as seen at the DUT port.
  logic [7:0] acc_data[$];
  int         acc_cnt[$];
  int         acc_cyc[$];
  logic [3:0] out_nib[$];

  always @(posedge clk) begin
    cyc++;
    if (rst2_n && b2.out_valid && b2.out_ready) begin
      acc_data.push_back(b2.out_data);
      acc_cnt.push_back(int'(b2.out_count));
      acc_cyc.push_back(cyc);
      for (int i = 0; i < int'(b2.out_count) && i < 2; i++) out_nib.push_back(b2.out_data[i*4 +: 4]);
    end
  end

  task automatic push_nib2(input logic [3:0] v);
    push2 = 1'b1;
    push2_data = v;
    @(negedge clk);
    push2 = 1'b0;
  endtask

  task automatic push_nib4(input logic [3:0] v);
    push4 = 1'b1;
    push4_data = v;
    @(negedge clk);
    push4 = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (acc_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, acc_data.size() >= n, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, na, k;
    logic [7:0] exp2[4];
    logic [7:0] exp3[3];

    b2.flush = 1'b0; b2.out_ready = 1'b0;
    b4.flush = 1'b0; b4.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", b2.out_valid, 1'b0);
    chk("rst_data", b2.out_data, 8'h00);
    chk("rst_count", b2.out_count, 2'd0);
    chk("rst_incr", b2.fifo_read_increment, 1'b0);
    rst2_n = 1'b1;
    rst4_n = 1'b1;
    @(negedge clk);

    // 1) two nibbles -> one word 0xA3
    b2.out_ready = 1'b1;
    base = pops2;
    k = vcnt2;
    push_nib2(4'h3);
    push_nib2(4'hA);
    wait_acc(1, 20, "t1_timeout");
    repeat (3) @(negedge clk);
    chk("t1_pops", pops2 - base, 2);
    chk("t1_word", acc_data[0], 8'hA3);
    chk("t1_count", acc_cnt[0], 2);
    chk("t1_valid_cycles", vcnt2 - k, 1);

    // 2) streaming 0x1..0x8
    na = acc_data.size();
    for (int v = 1; v <= 8; v++) push_nib2(4'(v));
    wait_acc(na + 4, 40, "t2_timeout");
    repeat (3) @(negedge clk);
    exp2[0] = 8'h21; exp2[1] = 8'h43; exp2[2] = 8'h65; exp2[3] = 8'h87;
    for (int i = 0; i < 4; i++) begin
      chk("t2_word", acc_data[na+i], exp2[i]);
      if (i > 0) chk("t2_spacing", acc_cyc[na+i] - acc_cyc[na+i-1], 2);
    end

    // 3) backpressure with six nibbles
    b2.out_ready = 1'b0;
    na = acc_data.size();
    base = pops2;
    push_nib2(4'hB); push_nib2(4'hC); push_nib2(4'hD);
    push_nib2(4'hE); push_nib2(4'hF); push_nib2(4'h0);
    repeat (10) @(negedge clk);
    chk("t3_pops_stalled", pops2 - base, 2);
    chk("t3_valid", b2.out_valid, 1'b1);
    chk("t3_data", b2.out_data, 8'hCB);
    chk("t3_incr", b2.fifo_read_increment, 1'b0);
    b2.out_ready = 1'b1;
    wait_acc(na + 3, 30, "t3_timeout");
    repeat (3) @(negedge clk);
    exp3[0] = 8'hCB; exp3[1] = 8'hED; exp3[2] = 8'h0F;
    for (int i = 0; i < 3; i++) chk("t3_word", acc_data[na+i], exp3[i]);

    // 4) single nibble then flush; then flush with nothing held
    na = acc_data.size();
    push_nib2(4'h5);
    repeat (4) @(negedge clk);
    chk("t4_no_partial", b2.out_valid, 1'b0);
    b2.flush = 1'b1;
    @(negedge clk);
    b2.flush = 1'b0;
    wait_acc(na + 1, 20, "t4_timeout");
    repeat (2) @(negedge clk);
    chk("t4_word", acc_data[na], 8'h05);
    chk("t4_count", acc_cnt[na], 1);
    na = acc_data.size();
    b2.flush = 1'b1;
    repeat (5) @(negedge clk);
    b2.flush = 1'b0;
    chk("t4_empty_flush", acc_data.size(), na);
    chk("t4_empty_valid", b2.out_valid, 1'b0);

    // 6) random empty/ready/flush stimulus
    for (int c = 0; c < 600; c++) begin
      push2 = ($urandom % 2) == 0;
      push2_data = 4'($urandom);
      b2.out_ready = ($urandom % 4) != 0;
      b2.flush = ($urandom % 10) == 0;
      @(negedge clk);
    end
    push2 = 1'b0;
    b2.out_ready = 1'b1;
    b2.flush = 1'b1;
    k = 0;
    while ((q2.size() != 0 || m_pend.size() != 0 || b2.out_valid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    b2.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_drained", k < 3000, 1'b1);
    chk("t6_total", out_nib.size(), pushed2.size());
    for (int i = 0; i < pushed2.size() && i < out_nib.size(); i++) begin
      if (out_nib[i] !== pushed2[i]) chk("t6_order", out_nib[i], pushed2[i]);
    end

    // 5) PACK=4: reset mid-word discards gathered nibbles
    b4.out_ready = 1'b1;
    push_nib4(4'h1);
    push_nib4(4'h2);
    k = 0;
    while (pops4 < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_pops", pops4, 2);
    chk("t5_partial_count", b4.out_count, 3'd2);
    chk("t5_partial_valid", b4.out_valid, 1'b0);
    #2 rst4_n = 1'b0;
    #1;
    chk("t5_rst_count", b4.out_count, 3'd0);
    chk("t5_rst_data", b4.out_data, 16'h0000);
    chk("t5_rst_incr", b4.fifo_read_increment, 1'b0);
    @(negedge clk);
    rst4_n = 1'b1;
    @(negedge clk);
    push_nib4(4'h9); push_nib4(4'h8); push_nib4(4'h7); push_nib4(4'h6);
    k = 0;
    while (!b4.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_valid", b4.out_valid, 1'b1);
    chk("t5_word", b4.out_data, 16'h6789);
    chk("t5_count", b4.out_count, 3'd4);
    repeat (2) @(negedge clk);
    chk("t5_accepted", b4.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
